// File: rtl/mult_seq_pkg.sv
// Shared types and default sizing for the sequential multiply controller.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_PULL  = 3'd1,
        ST_MULT  = 3'd2,
        ST_ROUND = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int DEF_NUM_SLICES = 4;
    localparam int DEF_NUM_TAPS   = 4;

endpackage

// File: rtl/mult_seq_cnt.sv
// Modulo-N up-counter with enable and sync clear; o_wrap flags the terminal count N-1.
module mult_seq_cnt #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a sliced multiply-accumulate: per tap PULL(1) + MULT(NUM_SLICES), then ROUND and HOLD until out_ready.
// Stalls in WAIT while the FIFO is empty; optional stall_cnt output under MULT_SEQ_STALL_CNT_EN.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int NUM_SLICES = DEF_NUM_SLICES,
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    localparam int SW = $clog2(NUM_SLICES),
    localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PushIn,
    input  logic          PushCoef,
    input  logic          fifo_empty,
    input  logic          out_ready,
    output logic [SW-1:0] multiplier_mux_sel,
    output logic          pp_valid,
    output logic          final_en,
    output logic          fifoPullOut,
    output logic [TW-1:0] coef_wr_addr,
    output logic [TW-1:0] tap_idx,
    output logic          result_valid,
    output logic          busy,
    output logic          coef_ready,
    output logic          err
`ifdef MULT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    state_t        r_state;
    logic          r_pull;
    logic          r_pp;
    logic          r_final;
    logic          r_rv;
    logic          r_coef_ready;
    logic          r_err;

    logic [SW-1:0] w_slice;
    logic          w_slice_wrap;
    logic [TW-1:0] w_tap;
    logic          w_tap_wrap;
    logic [TW-1:0] w_addr;
    logic          w_addr_wrap;
    logic          w_busy;
    logic          w_coef_wr;

    assign w_busy    = (r_state != ST_WAIT) || (w_tap != '0);
    assign w_coef_wr = PushCoef && !w_busy;

    mult_seq_cnt #(.N(NUM_SLICES), .W(SW)) u_slice_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_state == ST_MULT),
        .i_clr  (1'b0),
        .o_cnt  (w_slice),
        .o_wrap (w_slice_wrap)
    );

    // tap_idx stays at NUM_TAPS-1 through ROUND and clears on the way into HOLD
    mult_seq_cnt #(.N(NUM_TAPS), .W(TW)) u_tap_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_en   ((r_state == ST_MULT) && w_slice_wrap && !w_tap_wrap),
        .i_clr  (r_state == ST_ROUND),
        .o_cnt  (w_tap),
        .o_wrap (w_tap_wrap)
    );

    mult_seq_cnt #(.N(NUM_TAPS), .W(TW)) u_addr_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_coef_wr),
        .i_clr  (1'b0),
        .o_cnt  (w_addr),
        .o_wrap (w_addr_wrap)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_WAIT;
            r_pull  <= 1'b0;
            r_pp    <= 1'b0;
            r_final <= 1'b0;
            r_rv    <= 1'b0;
        end else begin
            r_pull  <= 1'b0;
            r_pp    <= 1'b0;
            r_final <= 1'b0;
            r_rv    <= 1'b0;
            case (r_state)
                ST_WAIT: begin
                    if (r_coef_ready && !fifo_empty) begin
                        r_state <= ST_PULL;
                        r_pull  <= 1'b1;
                    end
                end
                ST_PULL: begin
                    r_state <= ST_MULT;
                    r_pp    <= 1'b1;
                end
                ST_MULT: begin
                    if (!w_slice_wrap) begin
                        r_pp <= 1'b1;
                    end else if (w_tap_wrap) begin
                        r_state <= ST_ROUND;
                        r_final <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_ROUND: begin
                    r_state <= ST_HOLD;
                    r_rv    <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_rv <= 1'b1;
                    end
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_coef_ready <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_coef_wr && w_addr_wrap) begin
                r_coef_ready <= 1'b1;
            end
            if ((PushCoef && w_busy) || (PushIn && !r_coef_ready)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef MULT_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_WAIT) && (w_tap != '0) && fifo_empty
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // slice counter wraps back to 0 on the last MULT cycle, so it reads 0 elsewhere
    assign multiplier_mux_sel = w_slice;
    assign pp_valid           = r_pp;
    assign final_en           = r_final;
    assign fifoPullOut        = r_pull;
    assign coef_wr_addr       = w_addr;
    assign tap_idx            = w_tap;
    assign result_valid       = r_rv;
    assign busy               = w_busy;
    assign coef_ready         = r_coef_ready;
    assign err                = r_err;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: default 4x4 instance plus a 3-slice, 1-tap instance.
module tb_mult_seq_ctrl;

    logic       clk;
    int         n_vec;
    int         n_err;

    logic       rst_n, push_in, push_coef, fifo_empty, out_ready;
    logic [1:0] sel;
    logic       pp, fin, pull, rv, busy, cready, err;
    logic [1:0] addr, tap;
`ifdef MULT_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic       b_rst_n, b_push_in, b_push_coef, b_fifo_empty, b_out_ready;
    logic [1:0] b_sel;
    logic       b_pp, b_fin, b_pull, b_rv, b_busy, b_cready, b_err;
    logic [0:0] b_addr, b_tap;

    mult_seq_ctrl #(.NUM_SLICES(4), .NUM_TAPS(4)) u_dut (
        .clk                (clk),
        .reset              (rst_n),
        .PushIn             (push_in),
        .PushCoef           (push_coef),
        .fifo_empty         (fifo_empty),
        .out_ready          (out_ready),
        .multiplier_mux_sel (sel),
        .pp_valid           (pp),
        .final_en           (fin),
        .fifoPullOut        (pull),
        .coef_wr_addr       (addr),
        .tap_idx            (tap),
        .result_valid       (rv),
        .busy               (busy),
        .coef_ready         (cready),
        .err                (err)
`ifdef MULT_SEQ_STALL_CNT_EN
        ,
        .stall_cnt          (stall_cnt)
`endif
    );

    mult_seq_ctrl #(.NUM_SLICES(3), .NUM_TAPS(1)) u_dut_b (
        .clk                (clk),
        .reset              (b_rst_n),
        .PushIn             (b_push_in),
        .PushCoef           (b_push_coef),
        .fifo_empty         (b_fifo_empty),
        .out_ready          (b_out_ready),
        .multiplier_mux_sel (b_sel),
        .pp_valid           (b_pp),
        .final_en           (b_fin),
        .fifoPullOut        (b_pull),
        .coef_wr_addr       (b_addr),
        .tap_idx            (b_tap),
        .result_valid       (b_rv),
        .busy               (b_busy),
        .coef_ready         (b_cready),
        .err                (b_err)
`ifdef MULT_SEQ_STALL_CNT_EN
        ,
        .stall_cnt          ()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int m;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; push_in = 1'b0; push_coef = 1'b0; fifo_empty = 1'b1; out_ready = 1'b1;
        b_rst_n = 1'b0; b_push_in = 1'b0; b_push_coef = 1'b0; b_fifo_empty = 1'b1; b_out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cready", 32'(cready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_tap", 32'(tap), 0);
        chk("rst_strobes", 32'({pull, pp, fin, rv}), 0);
        chk("rst_sel", 32'(sel), 0);
        rst_n = 1'b1;
        b_rst_n = 1'b1;

        // PushIn before coefficients are loaded flags an error
        @(negedge clk);
        push_in = 1'b1;
        @(negedge clk);
        push_in = 1'b0;
        chk("pushin_err", 32'(err), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 0);
        rst_n = 1'b1;

        // coefficient load: address presented 0..3 then wraps, coef_ready after the 4th
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("coef_addr", 32'(addr), 32'(k));
            chk("coef_ready_early", 32'(cready), 0);
            push_coef = 1'b1;
        end
        @(negedge clk);
        push_coef = 1'b0;
        chk("coef_addr_wrap", 32'(addr), 0);
        chk("coef_ready", 32'(cready), 1);
        chk("coef_err", 32'(err), 0);

        // full 4-tap accumulation with a continuously non-empty FIFO
        fifo_empty = 1'b0;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            m = cyc % 6;
            chk("acc_pull", 32'(pull), 32'(m == 1 && cyc <= 19));
            chk("acc_pp", 32'(pp), 32'(cyc <= 23 && m >= 2));
            chk("acc_sel", 32'(sel), (cyc <= 23 && m >= 2) ? 32'(m - 2) : 0);
            chk("acc_tap", 32'(tap), (cyc <= 24) ? ((cyc / 6 > 3) ? 3 : 32'(cyc / 6)) : 0);
            chk("acc_final", 32'(fin), 32'(cyc == 24));
            chk("acc_rv", 32'(rv), 32'(cyc == 25));
            chk("acc_busy", 32'(busy), 32'(cyc <= 25));
            if (cyc == 24) fifo_empty = 1'b1;
        end

        // FIFO stall after tap 0, then a 10-cycle downstream stall in HOLD
        fifo_empty = 1'b0;
        for (int cyc = 1; cyc <= 43; cyc++) begin
            @(negedge clk);
            if (cyc >= 6 && cyc <= 13) begin
                chk("stall_tap", 32'(tap), 1);
                chk("stall_pp", 32'(pp), 0);
                chk("stall_pull", 32'(pull), 0);
            end
            if (cyc == 14) begin
                chk("stall_resume_pull", 32'(pull), 1);
                chk("stall_resume_tap", 32'(tap), 1);
`ifdef MULT_SEQ_STALL_CNT_EN
                chk("stall_cnt", 32'(stall_cnt), 7);
`endif
            end
            if (cyc == 31) chk("hold_final", 32'(fin), 1);
            if (cyc >= 32 && cyc <= 42) begin
                chk("hold_rv", 32'(rv), 1);
                chk("hold_pull", 32'(pull), 0);
                chk("hold_busy", 32'(busy), 1);
            end
            if (cyc == 43) begin
                chk("hold_release_rv", 32'(rv), 0);
                chk("hold_release_busy", 32'(busy), 0);
            end
            if (cyc == 5)  fifo_empty = 1'b1;
            if (cyc == 13) fifo_empty = 1'b0;
            if (cyc == 14) out_ready = 1'b0;
            if (cyc == 42) out_ready = 1'b1;
            if (cyc == 43) fifo_empty = 1'b1;
        end

        // PushCoef during MULT, then reset in MULT slice 2 of tap 1
        fifo_empty = 1'b0;
        for (int g = 1; g <= 11; g++) begin
            @(negedge clk);
            push_coef = 1'b0;
            if (g == 2) push_coef = 1'b1;
            if (g == 3) begin
                chk("busy_coef_err", 32'(err), 1);
                chk("busy_coef_addr", 32'(addr), 0);
                chk("busy_coef_sel", 32'(sel), 1);
            end
            if (g == 10) begin
                chk("pre_rst_sel", 32'(sel), 2);
                chk("pre_rst_tap", 32'(tap), 1);
                rst_n = 1'b0;
                fifo_empty = 1'b1;
            end
            if (g == 11) begin
                chk("mid_rst_tap", 32'(tap), 0);
                chk("mid_rst_cready", 32'(cready), 0);
                chk("mid_rst_err", 32'(err), 0);
                chk("mid_rst_strobes", 32'({pull, pp, fin, rv}), 0);
                chk("mid_rst_sel", 32'(sel), 0);
                chk("mid_rst_busy", 32'(busy), 0);
                rst_n = 1'b1;
            end
        end

        // 3-slice, 1-tap instance
        b_push_coef = 1'b1;
        @(negedge clk);
        b_push_coef = 1'b0;
        chk("b_cready", 32'(b_cready), 1);
        chk("b_addr", 32'(b_addr), 0);
        b_fifo_empty = 1'b0;
        for (int h = 1; h <= 7; h++) begin
            @(negedge clk);
            chk("b_pull", 32'(b_pull), 32'(h == 1));
            chk("b_pp", 32'(b_pp), 32'(h >= 2 && h <= 4));
            chk("b_sel", 32'(b_sel), (h >= 2 && h <= 4) ? 32'(h - 2) : 0);
            chk("b_final", 32'(b_fin), 32'(h == 5));
            chk("b_rv", 32'(b_rv), 32'(h == 6));
            chk("b_tap", 32'(b_tap), 0);
            chk("b_busy", 32'(b_busy), 32'(h <= 6));
            if (h == 5) b_fifo_empty = 1'b1;
        end
        chk("b_err", 32'(b_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
